// File: rtl/hacd_axi_ram_pkg.sv
// Shared constants for the HACD AXI4 RAM responder: bus defaults, burst/resp codes, FSM states.
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 64
`endif
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 32
`endif
`ifndef HACD_AXI4_ID_WIDTH
`define HACD_AXI4_ID_WIDTH 4
`endif

package hacd_axi_ram_pkg;

  localparam int AXI_DATA_WIDTH = `HACD_AXI4_DATA_WIDTH;
  localparam int AXI_ADDR_WIDTH = `HACD_AXI4_ADDR_WIDTH;
  localparam int AXI_ID_WIDTH   = `HACD_AXI4_ID_WIDTH;
  localparam int AXI_USER_WIDTH = 1;
  localparam logic [63:0] DDR_START_ADDR = 64'h0000_0000_8000_0000;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [1:0] wr_state_t;
  localparam wr_state_t W_IDLE  = 2'd0;
  localparam wr_state_t W_BURST = 2'd1;
  localparam wr_state_t W_RESP  = 2'd2;

  typedef logic [0:0] rd_state_t;
  localparam rd_state_t R_IDLE  = 1'b0;
  localparam rd_state_t R_BURST = 1'b1;

  // A decode error outranks a slave error when both apply.
  function automatic logic [1:0] resp_of(input logic dec, input logic err);
    if (dec) return RESP_DECERR;
    if (err) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/hacd_axi_burst_addr.sv
// Combinational AXI4 next-beat address for FIXED, INCR and WRAP bursts.
module hacd_axi_burst_addr
  import hacd_axi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_bytes;
  logic [ADDR_WIDTH-1:0] wrap_base;

  // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    step       = ADDR_WIDTH'(1) << size;
    aligned    = addr & ~(step - ADDR_WIDTH'(1));
    incr       = aligned + step;
    wrap_bytes = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    wrap_base  = aligned & ~(wrap_bytes - ADDR_WIDTH'(1));
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (incr == wrap_base + wrap_bytes) ? wrap_base : incr;
      default:     next_addr = incr;
    endcase
  end

endmodule

// File: rtl/hacd_axi_ram_slave.sv
// AXI4 RAM responder standing in for DDR behind the HACD crossbar; independent write and read paths.
// Optional: define HACD_AXI_RAM_DECERR_EN to answer out-of-range burst start addresses with DECERR.
module hacd_axi_ram_slave
  import hacd_axi_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int                    ID_WIDTH   = AXI_ID_WIDTH + 1,
  parameter int                    USER_WIDTH = AXI_USER_WIDTH,
  parameter int                    MEM_AW     = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DDR_START_ADDR),
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic [3:0]            s_axi_awqos,
  input  logic [3:0]            s_axi_awregion,
  input  logic [USER_WIDTH-1:0] s_axi_awuser,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic [USER_WIDTH-1:0] s_axi_wuser,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic [USER_WIDTH-1:0] s_axi_buser,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arqos,
  input  logic [3:0]            s_axi_arregion,
  input  logic [USER_WIDTH-1:0] s_axi_aruser,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic [USER_WIDTH-1:0] s_axi_ruser,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int         OFF_W    = $clog2(STRB_WIDTH);
  localparam int         IDX_W    = MEM_AW - OFF_W;
  localparam int         WORDS    = 2 ** IDX_W;
  localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> OFF_W);
  endfunction

  // Active byte lanes of a beat: from the address offset up to the end of its 2^size window.
  function automatic logic [STRB_WIDTH-1:0] lane_mask(input logic [OFF_W-1:0] off, input logic [2:0] size);
    logic [OFF_W:0] lo;
    logic [OFF_W:0] hi;
    lo = {1'b0, off};
    hi = ((lo >> size) << size) + ((OFF_W + 1)'(1) << size);
    for (int i = 0; i < STRB_WIDTH; i++)
      lane_mask[i] = ((OFF_W + 1)'(i) >= lo) && ((OFF_W + 1)'(i) < hi);
  endfunction

  function automatic logic bad_burst(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    return (size > MAX_SIZE) || (burst == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  logic aw_dec;
  logic ar_dec;
`ifdef HACD_AXI_RAM_DECERR_EN
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ((a - BASE_ADDR) >> MEM_AW) == '0;
  endfunction
  assign aw_dec = !in_range(s_axi_awaddr);
  assign ar_dec = !in_range(s_axi_araddr);
`else
  assign aw_dec = 1'b0;
  assign ar_dec = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // Write path state
  wr_state_t             w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] w_next;
  logic [7:0]            w_len;
  logic [7:0]            w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err;
  logic                  w_dec;
  logic                  w_fire;
  logic                  w_final;
  logic                  mem_we;
  logic [STRB_WIDTH-1:0] mem_be;

  hacd_axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_addr (
    .addr      (w_addr),
    .len       (w_len),
    .size      (w_size),
    .burst     (w_burst),
    .next_addr (w_next)
  );

  assign w_fire  = (w_state == W_BURST) && s_axi_wvalid && s_axi_wready;
  assign w_final = s_axi_wlast || (w_cnt == w_len);
  assign mem_we  = w_fire && !w_err && !w_dec;
  assign mem_be  = s_axi_wstrb & lane_mask(w_addr[OFF_W-1:0], w_size);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= RESP_OKAY;
      w_addr        <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_size        <= '0;
      w_burst       <= '0;
      w_err         <= 1'b0;
      w_dec         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            s_axi_bid     <= s_axi_awid;
            w_addr        <= s_axi_awaddr;
            w_len         <= s_axi_awlen;
            w_size        <= s_axi_awsize;
            w_burst       <= s_axi_awburst;
            w_cnt         <= '0;
            w_err         <= bad_burst(s_axi_awlen, s_axi_awsize, s_axi_awburst);
            w_dec         <= aw_dec;
            w_state       <= W_BURST;
          end
        end
        W_BURST: begin
          if (w_fire) begin
            w_addr <= w_next;
            w_cnt  <= w_cnt + 8'd1;
            if (w_final) begin
              // A wlast that disagrees with the beat count poisons the whole burst response.
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= resp_of(w_dec, w_err || (s_axi_wlast != (w_cnt == w_len)));
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: RAM contents carry no reset; a reset branch here would stop it mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_WIDTH; b++)
        if (mem_be[b]) mem[word_idx(w_addr)][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
    end
  end

  // Read path state
  rd_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_next;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;
  logic                  r_dec;
  logic                  ar_err;

  hacd_axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_addr (
    .addr      (r_addr),
    .len       (r_len),
    .size      (r_size),
    .burst     (r_burst),
    .next_addr (r_next)
  );

  assign ar_err = bad_burst(s_axi_arlen, s_axi_arsize, s_axi_arburst);

  // RAM is read with non-blocking loads, so a same-edge write is seen only by later beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rlast   <= 1'b0;
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_err         <= 1'b0;
      r_dec         <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rid     <= s_axi_arid;
            s_axi_rresp   <= resp_of(ar_dec, ar_err);
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            s_axi_rdata   <= (ar_err || ar_dec) ? '0 : mem[word_idx(s_axi_araddr)];
            r_addr        <= s_axi_araddr;
            r_len         <= s_axi_arlen;
            r_size        <= s_axi_arsize;
            r_burst       <= s_axi_arburst;
            r_cnt         <= '0;
            r_err         <= ar_err;
            r_dec         <= ar_dec;
            r_state       <= R_BURST;
          end
        end
        R_BURST: begin
          if (s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_addr      <= r_next;
              r_cnt       <= r_cnt + 8'd1;
              s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
              s_axi_rdata <= (r_err || r_dec) ? '0 : mem[word_idx(r_next)];
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign s_axi_buser = '0;
  assign s_axi_ruser = '0;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                           s_axi_awuser, s_axi_wuser, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                           s_axi_arqos, s_axi_arregion, s_axi_aruser};

endmodule

// File: tb/tb_hacd_axi_ram_slave.sv
// Directed bench for hacd_axi_ram_slave (64-bit data, base 0x8000_0000, 64 KB RAM).
module tb_hacd_axi_ram_slave;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic [4:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic [0:0]  buser, ruser;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] wb [16];
  logic [63:0] rd_data [16];
  logic        rd_last [16];
  logic [4:0]  rd_id;
  logic [1:0]  rd_resp;
  int          rd_n;
  int          rd_lat;
  logic        stall_bad;
  logic [4:0]  got_bid;
  logic [1:0]  got_bresp;

  hacd_axi_ram_slave dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
    .s_axi_awqos(4'd0), .s_axi_awregion(4'd0), .s_axi_awuser(1'b0),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wuser(1'b0),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_buser(buser), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
    .s_axi_arqos(4'd0), .s_axi_arregion(4'd0), .s_axi_aruser(1'b0),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_ruser(ruser), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL timeout %s: observed no handshake, expected one within 50 cycles", tag);
  endtask

  task automatic aw_send(input logic [4:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t;
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin step(); t++; end
    if (!awready) timeout("aw");
    step();
    awvalid = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [7:0] strb);
    int t;
    aw_send(id, a, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wb[i]; wstrb = strb; wlast = (i == int'(len)); wvalid = 1'b1;
      t = 0;
      while (!wready && t < 50) begin step(); t++; end
      if (!wready) timeout("w");
      step();
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 50) begin step(); t++; end
    if (!bvalid) timeout("b");
    got_bid = bid; got_bresp = bresp;
    step();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [7:0] rr_pat);
    int t;
    int cyc;
    logic        have_snap;
    logic [63:0] snap_d;
    logic [4:0]  snap_id;
    logic        snap_l;
    arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin step(); t++; end
    if (!arready) timeout("ar");
    step();
    arvalid = 1'b0;
    rd_n = 0; rd_lat = 0; stall_bad = 1'b0; have_snap = 1'b0; cyc = 0;
    snap_d = '0; snap_id = '0; snap_l = 1'b0;
    while (rd_n <= int'(len) && cyc < 200) begin
      rready = rr_pat[cyc % 8];
      if (rvalid) begin
        if (have_snap && (rdata !== snap_d || rid !== snap_id || rlast !== snap_l)) stall_bad = 1'b1;
        if (rready) begin
          rd_data[rd_n] = rdata; rd_last[rd_n] = rlast; rd_id = rid; rd_resp = rresp;
          rd_n++;
          have_snap = 1'b0;
        end else begin
          snap_d = rdata; snap_id = rid; snap_l = rlast; have_snap = 1'b1;
        end
      end else if (rd_n == 0) begin
        rd_lat++;
      end
      step();
      cyc++;
    end
    rready = 1'b0;
    if (rd_n <= int'(len)) timeout("r");
  endtask

  initial begin
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    rst = 1'b0;
    #3 rst = 1'b1;
    #2;
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_bid_bresp", {bid, bresp}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rid_rresp_rlast", {rid, rresp, rlast}, 0);
    step(); step();
    rst = 1'b0;
    step();
    check("idle_awready", awready, 1);
    check("idle_arready", arready, 1);

    // INCR write then read-back
    for (int i = 0; i < 4; i++) wb[i] = 64'(i + 1);
    do_write(5'h0A, BASE, 8'd3, 3'd3, 2'b01, 8'hFF);
    check("incr_bresp", got_bresp, 2'b00);
    check("incr_bid", got_bid, 5'h0A);
    check("incr_bvalid_drop", bvalid, 0);
    do_read(5'h13, BASE, 8'd3, 3'd3, 2'b01, 8'hFF);
    check("incr_rd_latency", rd_lat, 0);
    check("incr_rd_beats", rd_n, 4);
    check("incr_rid", rd_id, 5'h13);
    check("incr_rresp", rd_resp, 2'b00);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("incr_rdata%0d", i), rd_data[i], 64'(i + 1));
      check($sformatf("incr_rlast%0d", i), rd_last[i], (i == 3) ? 1 : 0);
    end
    check("rd_done_rvalid", rvalid, 0);

    // WRAP read from word 2: words 2,3,0,1
    do_read(5'h01, BASE + 32'd16, 8'd3, 3'd3, 2'b10, 8'hFF);
    check("wrap_rdata0", rd_data[0], 64'd3);
    check("wrap_rdata1", rd_data[1], 64'd4);
    check("wrap_rdata2", rd_data[2], 64'd1);
    check("wrap_rdata3", rd_data[3], 64'd2);

    // Narrow byte write at offset 5
    wb[0] = 64'h1122_3344_5566_7788;
    do_write(5'h02, BASE + 32'd5, 8'd0, 3'd0, 2'b01, 8'hFF);
    check("narrow_bresp", got_bresp, 2'b00);
    do_read(5'h02, BASE, 8'd0, 3'd3, 2'b01, 8'hFF);
    check("narrow_rdata", rd_data[0], 64'h0000_3300_0000_0001);
    check("narrow_rlast", rd_last[0], 1);

    // Oversized beats and an illegal wrap length are rejected
    wb[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(5'h03, BASE, 8'd0, 3'd4, 2'b01, 8'hFF);
    check("oversize_bresp", got_bresp, 2'b10);
    wb[1] = 64'hFFFF_FFFF_FFFF_FFFF; wb[2] = wb[1];
    do_write(5'h03, BASE, 8'd2, 3'd3, 2'b10, 8'hFF);
    check("badwrap_bresp", got_bresp, 2'b10);
    do_read(5'h04, BASE, 8'd0, 3'd4, 2'b01, 8'hFF);
    check("oversize_rresp", rd_resp, 2'b10);
    check("oversize_rdata", rd_data[0], 64'd0);
    do_read(5'h04, BASE, 8'd0, 3'd3, 2'b01, 8'hFF);
    check("err_no_update", rd_data[0], 64'h0000_3300_0000_0001);

    // Stalled len=7 read with rready 1-0-0-1
    for (int i = 0; i < 8; i++) wb[i] = 64'h100 + 64'(i);
    do_write(5'h05, BASE + 32'd64, 8'd7, 3'd3, 2'b01, 8'hFF);
    check("stall_wr_bresp", got_bresp, 2'b00);
    do_read(5'h06, BASE + 32'd64, 8'd7, 3'd3, 2'b01, 8'b1001_1001);
    check("stall_beats", rd_n, 8);
    check("stall_stable", stall_bad, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("stall_rdata%0d", i), rd_data[i], 64'h100 + 64'(i));
      check($sformatf("stall_rlast%0d", i), rd_last[i], (i == 7) ? 1 : 0);
    end

    // Read and write to word 1 on the same edge: read sees the old value
    aw_send(5'h07, BASE + 32'd8, 8'd0, 3'd3, 2'b01);
    check("rbw_wready", wready, 1);
    check("rbw_arready", arready, 1);
    arid = 5'h08; araddr = BASE + 32'd8; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
    wdata = 64'hDEAD; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    step();
    arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    check("rbw_rvalid", rvalid, 1);
    check("rbw_old_data", rdata, 64'd2);
    check("rbw_bvalid", bvalid, 1);
    rready = 1'b1; bready = 1'b1;
    step();
    rready = 1'b0; bready = 1'b0;
    do_read(5'h08, BASE + 32'd8, 8'd0, 3'd3, 2'b01, 8'hFF);
    check("rbw_new_data", rd_data[0], 64'hDEAD);

    // Write just past the top of the RAM window
    wb[0] = 64'h55;
    do_write(5'h09, BASE + 32'h0001_0000, 8'd0, 3'd3, 2'b01, 8'hFF);
`ifdef HACD_AXI_RAM_DECERR_EN
    check("oor_bresp", got_bresp, 2'b11);
    do_read(5'h09, BASE, 8'd0, 3'd3, 2'b01, 8'hFF);
    check("oor_ram_unchanged", rd_data[0], 64'h0000_3300_0000_0001);
    do_read(5'h09, BASE + 32'h0001_0000, 8'd0, 3'd3, 2'b01, 8'hFF);
    check("oor_rresp", rd_resp, 2'b11);
    check("oor_rdata", rd_data[0], 64'd0);
`else
    check("oor_bresp", got_bresp, 2'b00);
    do_read(5'h09, BASE, 8'd0, 3'd3, 2'b01, 8'hFF);
    check("oor_wraps_to_0", rd_data[0], 64'h55);
`endif

    // Reset in the middle of a len=7 write
    aw_send(5'h0B, BASE + 32'd128, 8'd7, 3'd3, 2'b01);
    wstrb = 8'hFF; wvalid = 1'b1;
    wdata = 64'hA0; step();
    wdata = 64'hA1; step();
    wdata = 64'hA2;
    #2 rst = 1'b1;
    #1;
    check("midrst_wready", wready, 0);
    check("midrst_bvalid", bvalid, 0);
    wvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    check("postrst_awready", awready, 1);
    check("postrst_bvalid", bvalid, 0);
    wb[0] = 64'd7; wb[1] = 64'd8;
    do_write(5'h0C, BASE + 32'd128, 8'd1, 3'd3, 2'b01, 8'hFF);
    check("postrst_bresp", got_bresp, 2'b00);
    check("postrst_bid", got_bid, 5'h0C);
    do_read(5'h0D, BASE + 32'd128, 8'd1, 3'd3, 2'b01, 8'hFF);
    check("postrst_rdata0", rd_data[0], 64'd7);
    check("postrst_rdata1", rd_data[1], 64'd8);
    check("postrst_rlast1", rd_last[1], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
